// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the datapath mux / ALU select codes driven by the controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [1:0] ALU_SRC_B_REG    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational decode of FSM state (plus mem_ready / zero) into the
// datapath control strobes and mux selects.
module mc_ctrl_outputs
  import mips_pkg::*;
(
  input  state_t     state_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       pc_en_o,
  output logic       instr_done_o
);

  logic pc_write;
  logic branch;

  always_comb begin
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = ALU_SRC_B_REG;
    alu_op_o     = ALUOP_ADD;
    pc_src_o     = PC_SRC_ALU;
    instr_done_o = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    case (state_i)
      S_FETCH: begin
        alu_src_b_o = ALU_SRC_B_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write    = mem_ready_i;
      end
      S_DECODE:   alu_src_b_o = ALU_SRC_B_IMM_SH;
      S_MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_SRC_B_IMM;
      end
      S_MEMREAD:  iord_o = 1'b1;
      S_MEMWB: begin
        mem_to_reg_o = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      // Write strobe stays up through every stall cycle; only the accepted cycle retires.
      S_MEMWRITE: begin
        iord_o       = 1'b1;
        mem_write_o  = 1'b1;
        instr_done_o = mem_ready_i;
      end
      S_EXECUTE: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst_o    = 1'b1;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o  = 1'b1;
        alu_op_o     = ALUOP_SUB;
        pc_src_o     = PC_SRC_ALUOUT;
        branch       = 1'b1;
        instr_done_o = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = ALU_SRC_B_IMM;
      end
      S_ADDIWB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      S_JUMP: begin
        pc_src_o     = PC_SRC_JUMP;
        pc_write     = 1'b1;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
    pc_en_o = pc_write | (branch & zero_i);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences each instruction through shared
// memory/ALU/regfile states and counts retired instructions.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_dbg
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done) count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  mc_ctrl_outputs u_outputs (
    .state_i      (state_q),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .iord_o       (iord),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_src_o     (pc_src),
    .pc_en_o      (pc_en),
    .instr_done_o (instr_done)
  );

  assign illegal_op  = (state_q == S_DECODE) && !is_legal_op(opcode);
  assign instr_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: a cycle-by-cycle vector table plus reset and counter-wrap
// sequences, run against a 32-bit-counter and a 2-bit-counter instance.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic        pc_en, illegal_op, instr_done;
  logic [31:0] instr_count;
  logic [3:0]  state_dbg;

  logic        iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2, alu_src_a2;
  logic [1:0]  alu_src_b2, alu_op2, pc_src2;
  logic        pc_en2, illegal_op2, instr_done2;
  logic [1:0]  instr_count2;
  logic [3:0]  state_dbg2;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .illegal_op(illegal_op), .instr_done(instr_done), .instr_count(instr_count),
    .state_dbg(state_dbg)
  );

  mips_multicycle_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord2), .mem_write(mem_write2), .ir_write(ir_write2), .reg_dst(reg_dst2),
    .mem_to_reg(mem_to_reg2), .reg_write(reg_write2), .alu_src_a(alu_src_a2),
    .alu_src_b(alu_src_b2), .alu_op(alu_op2), .pc_src(pc_src2), .pc_en(pc_en2),
    .illegal_op(illegal_op2), .instr_done(instr_done2), .instr_count(instr_count2),
    .state_dbg(state_dbg2)
  );

  // Packed control word: iord mw irw rd m2r rw asa asb[2] aop[2] psrc[2] pcen ill done
  logic [15:0] ctrl_act, ctrl_act2;
  assign ctrl_act  = {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                      alu_src_b, alu_op, pc_src, pc_en, illegal_op, instr_done};
  assign ctrl_act2 = {iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2, alu_src_a2,
                      alu_src_b2, alu_op2, pc_src2, pc_en2, illegal_op2, instr_done2};

  function automatic logic [15:0] cw(input logic io, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, aop, psrc,
                                     input logic pcen, ill, done);
    return {io, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, pcen, ill, done};
  endfunction

  localparam logic [5:0] OPR = 6'b000000, OPLW = 6'b100011, OPSW = 6'b101011;
  localparam logic [5:0] OPBQ = 6'b000100, OPAI = 6'b001000, OPJ = 6'b000010, OPBAD = 6'b111111;

  logic [15:0] F1, F0, DEC, DECI, MADR, MRD, MWB, MW0, MW1, EXE, AWB, BRZ, BRN, AIE, AIWB, JMP;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctrl;
    int          cnt;
  } vec_t;

  vec_t vecs[33];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic z, input logic mr);
    @(negedge clk);
    opcode = op; zero = z; mem_ready = mr;
    #2;
  endtask

  initial begin
    F1   = cw(0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0);
    F0   = cw(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0);
    DEC  = cw(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,0);
    DECI = cw(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1,0);
    MADR = cw(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    MRD  = cw(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    MWB  = cw(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0,1);
    MW0  = cw(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0);
    MW1  = cw(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,1);
    EXE  = cw(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0);
    AWB  = cw(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0,1);
    BRZ  = cw(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0,1);
    BRN  = cw(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0,1);
    AIE  = cw(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0);
    AIWB = cw(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0,1);
    JMP  = cw(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0,1);

    // R-type
    vecs[0]  = '{OPR, 0, 1, 4'd0, F1, 0};
    vecs[1]  = '{OPR, 0, 1, 4'd1, DEC, 0};
    vecs[2]  = '{OPR, 0, 1, 4'd6, EXE, 0};
    vecs[3]  = '{OPR, 0, 1, 4'd7, AWB, 0};
    // lw with two stall cycles in MEMREAD
    vecs[4]  = '{OPLW, 0, 1, 4'd0, F1, 1};
    vecs[5]  = '{OPLW, 0, 1, 4'd1, DEC, 1};
    vecs[6]  = '{OPLW, 0, 1, 4'd2, MADR, 1};
    vecs[7]  = '{OPLW, 0, 0, 4'd3, MRD, 1};
    vecs[8]  = '{OPLW, 0, 0, 4'd3, MRD, 1};
    vecs[9]  = '{OPLW, 0, 1, 4'd3, MRD, 1};
    vecs[10] = '{OPLW, 0, 1, 4'd4, MWB, 1};
    // sw with one fetch stall and one MEMWRITE stall
    vecs[11] = '{OPSW, 0, 0, 4'd0, F0, 2};
    vecs[12] = '{OPSW, 0, 1, 4'd0, F1, 2};
    vecs[13] = '{OPSW, 0, 1, 4'd1, DEC, 2};
    vecs[14] = '{OPSW, 0, 1, 4'd2, MADR, 2};
    vecs[15] = '{OPSW, 0, 0, 4'd5, MW0, 2};
    vecs[16] = '{OPSW, 0, 1, 4'd5, MW1, 2};
    // beq taken, then not taken
    vecs[17] = '{OPBQ, 1, 1, 4'd0, F1, 3};
    vecs[18] = '{OPBQ, 1, 1, 4'd1, DEC, 3};
    vecs[19] = '{OPBQ, 1, 1, 4'd8, BRZ, 3};
    vecs[20] = '{OPBQ, 0, 1, 4'd0, F1, 4};
    vecs[21] = '{OPBQ, 0, 1, 4'd1, DEC, 4};
    vecs[22] = '{OPBQ, 0, 1, 4'd8, BRN, 4};
    // addi
    vecs[23] = '{OPAI, 0, 1, 4'd0, F1, 5};
    vecs[24] = '{OPAI, 0, 1, 4'd1, DEC, 5};
    vecs[25] = '{OPAI, 0, 1, 4'd9, AIE, 5};
    vecs[26] = '{OPAI, 0, 1, 4'd10, AIWB, 5};
    // illegal opcode: no count
    vecs[27] = '{OPBAD, 0, 1, 4'd0, F1, 6};
    vecs[28] = '{OPBAD, 0, 1, 4'd1, DECI, 6};
    // j
    vecs[29] = '{OPJ, 0, 1, 4'd0, F1, 6};
    vecs[30] = '{OPJ, 0, 1, 4'd1, DEC, 6};
    vecs[31] = '{OPJ, 0, 1, 4'd11, JMP, 6};
    vecs[32] = '{OPJ, 0, 0, 4'd0, F0, 7};

    #3;
    check("reset_state", {28'd0, state_dbg}, 32'd0);
    check("reset_ctrl", {16'd0, ctrl_act}, {16'd0, F0});
    check("reset_count", instr_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 33; i++) begin
      drive(vecs[i].op, vecs[i].z, vecs[i].mr);
      $display("vec %0d op=%b z=%b mr=%b state=%0d ctrl=%h count=%0d", i, vecs[i].op,
               vecs[i].z, vecs[i].mr, state_dbg, ctrl_act, instr_count);
      check($sformatf("v%0d_state", i), {28'd0, state_dbg}, {28'd0, vecs[i].st});
      check($sformatf("v%0d_ctrl", i), {16'd0, ctrl_act}, {16'd0, vecs[i].ctrl});
      check($sformatf("v%0d_count", i), instr_count, vecs[i].cnt);
      check($sformatf("v%0d_ctrl2", i), {16'd0, ctrl_act2}, {16'd0, vecs[i].ctrl});
      check($sformatf("v%0d_count2", i), {30'd0, instr_count2}, vecs[i].cnt % 4);
    end

    // Reset in the middle of a stalled store
    drive(OPSW, 0, 1);
    drive(OPSW, 0, 1);
    drive(OPSW, 0, 1);
    drive(OPSW, 0, 0);
    check("midsw_state", {28'd0, state_dbg}, 32'd5);
    check("midsw_mem_write", {31'd0, mem_write}, 32'd1);
    #1 rst = 1'b1;
    #1;
    $display("async reset: mem_write=%b state=%0d count=%0d", mem_write, state_dbg, instr_count);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_state", {28'd0, state_dbg}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_count2", {30'd0, instr_count2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Four jumps: the 2-bit counter wraps 3 -> 0
    for (int i = 0; i <= 12; i++) begin
      drive(OPJ, 0, 1);
      check($sformatf("j%0d_state", i), {28'd0, state_dbg},
            (i % 3 == 0) ? 32'd0 : (i % 3 == 1) ? 32'd1 : 32'd11);
      if (i % 3 == 0) begin
        $display("jump seq %0d count=%0d count2=%0d", i / 3, instr_count, instr_count2);
        check($sformatf("j%0d_count", i), instr_count, i / 3);
        check($sformatf("j%0d_count2", i), {30'd0, instr_count2}, (i / 3) % 4);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
